truth_table_checker: RTL and testbench

Self-checking response analyser for small combinational logic functions: the hardware counterpart of the stimulus-vector lab testbenches. It sweeps every input combination of an N-input DUT and waits a settle interval after each vector. It then samples the DUT output, compares it against a golden truth table held in a parameter, and reports the mismatch count and the first failing vector. It sits beside the DUT on the lab board or in a top-level bench, driving the DUT inputs and reading its single output.

---
 rtl/ttc_pkg.sv | 14 +
 rtl/ttc_settle_timer.sv | 35 +++
 rtl/truth_table_checker.sv | 132 +++++++++++++
 tb/tb_truth_table_checker.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/ttc_pkg.sv
// Shared definitions for the sweep-style truth table checkers.
// Holds the FSM state encoding and the settle timer width.
package ttc_pkg;

  localparam int TIMER_W = 8;

  typedef logic [1:0] ttc_state_t;

  localparam ttc_state_t ST_IDLE   = 2'd0;
  localparam ttc_state_t ST_SETTLE = 2'd1;
  localparam ttc_state_t ST_SAMPLE = 2'd2;
  localparam ttc_state_t ST_DONE   = 2'd3;

endpackage

// File: rtl/ttc_settle_timer.sv
// Loadable down-counter with a zero flag. It paces each vector of a sweep.
// Priority: load over decrement. The count holds at zero.
module ttc_settle_timer
  import ttc_pkg::*;
(
  input  logic               clk,
  input  logic               reset_n,
  input  logic               load,
  input  logic [TIMER_W-1:0] load_val,
  input  logic               dec,
  output logic               zero
);

  logic [TIMER_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (dec && (count_q != '0)) begin
      count_d = count_q - TIMER_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero = (count_q == '0);

endmodule

// File: rtl/truth_table_checker.sv
// Sweeps every input vector of an N_IN-input DUT, waits SETTLE cycles and compares f_in with EXPECTED.
// Optional macro TTC_STOP_ON_FAIL_EN: the sweep ends at the first mismatching vector.
//
// state     | meaning
// IDLE      | waiting for start after reset
// SETTLE    | vec_out held while the DUT output settles
// SAMPLE    | f_in compared against the golden bit, then advance or finish
// DONE      | results frozen until the next start
module truth_table_checker
  import ttc_pkg::*;
#(
  parameter int                     N_IN     = 3,
  parameter logic [(1<<N_IN)-1:0]   EXPECTED = 8'b1001_0110,
  parameter int                     SETTLE   = 2
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            start,
  input  logic            f_in,
  output logic [N_IN-1:0] vec_out,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   err_cnt,
  output logic [N_IN-1:0] first_fail,
  output logic            first_fail_vld
);

  localparam logic [TIMER_W-1:0] SETTLE_LOAD = TIMER_W'(SETTLE - 1);
  localparam logic [N_IN-1:0]    LAST_VEC    = {N_IN{1'b1}};

  ttc_state_t      state_q, state_d;
  logic [N_IN-1:0] vec_q, vec_d;
  logic [N_IN:0]   err_cnt_q, err_cnt_d;
  logic [N_IN-1:0] first_fail_q, first_fail_d;
  logic            first_fail_vld_q, first_fail_vld_d;
  logic            done_q, done_d;
  logic            timer_load, timer_dec, timer_zero;
  logic            mismatch, stop_now;

  ttc_settle_timer u_timer (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (timer_load),
    .load_val (SETTLE_LOAD),
    .dec      (timer_dec),
    .zero     (timer_zero)
  );

  assign mismatch = (f_in != EXPECTED[vec_q]);

  always_comb begin
    state_d          = state_q;
    vec_d            = vec_q;
    err_cnt_d        = err_cnt_q;
    first_fail_d     = first_fail_q;
    first_fail_vld_d = first_fail_vld_q;
    done_d           = done_q;
    timer_load       = 1'b0;
    timer_dec        = 1'b0;
    stop_now         = (vec_q == LAST_VEC);
`ifdef TTC_STOP_ON_FAIL_EN
    stop_now         = stop_now || mismatch;
`endif
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d          = ST_SETTLE;
          vec_d            = '0;
          err_cnt_d        = '0;
          first_fail_d     = '0;
          first_fail_vld_d = 1'b0;
          done_d           = 1'b0;
          timer_load       = 1'b1;
        end
      end
      ST_SETTLE: begin
        if (timer_zero) begin
          state_d = ST_SAMPLE;
        end else begin
          timer_dec = 1'b1;
        end
      end
      ST_SAMPLE: begin
        if (mismatch) begin
          err_cnt_d = err_cnt_q + (N_IN+1)'(1);
          if (!first_fail_vld_q) begin
            first_fail_d     = vec_q;
            first_fail_vld_d = 1'b1;
          end
        end
        if (stop_now) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end else begin
          vec_d      = vec_q + N_IN'(1);
          timer_load = 1'b1;
          state_d    = ST_SETTLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q          <= ST_IDLE;
      vec_q            <= '0;
      err_cnt_q        <= '0;
      first_fail_q     <= '0;
      first_fail_vld_q <= 1'b0;
      done_q           <= 1'b0;
    end else begin
      state_q          <= state_d;
      vec_q            <= vec_d;
      err_cnt_q        <= err_cnt_d;
      first_fail_q     <= first_fail_d;
      first_fail_vld_q <= first_fail_vld_d;
      done_q           <= done_d;
    end
  end

  // Status outputs decode flops only, so f_in never reaches an output combinationally.
  assign vec_out        = vec_q;
  assign busy           = (state_q == ST_SETTLE) || (state_q == ST_SAMPLE);
  assign done           = done_q;
  assign pass           = done_q && (err_cnt_q == '0);
  assign err_cnt        = err_cnt_q;
  assign first_fail     = first_fail_q;
  assign first_fail_vld = first_fail_vld_q;

endmodule

// File: tb/tb_truth_table_checker.sv
// Bench for truth_table_checker: behavioural DUT models, a result scoreboard and sweep timing checks.
module tb_truth_table_checker;

  localparam int N_IN   = 3;
  localparam int SETTLE = 2;
  localparam int NVEC   = 1 << N_IN;

  localparam int M_XOR    = 0;
  localparam int M_XNOR   = 1;
  localparam int M_FAULT5 = 2;

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic            start = 1'b0;
  logic            f_in;
  logic [N_IN-1:0] vec_out;
  logic            busy, done, pass, first_fail_vld;
  logic [N_IN:0]   err_cnt;
  logic [N_IN-1:0] first_fail;
  int              dut_mode = M_XOR;

  int checks = 0;
  int failures = 0;

  typedef struct {
    int err;
    int ff;
    int vld;
    int pass;
    int cycles;
  } result_t;

  result_t sb_q[$];

  truth_table_checker #(
    .N_IN     (N_IN),
    .EXPECTED (8'b1001_0110),
    .SETTLE   (SETTLE)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .start          (start),
    .f_in           (f_in),
    .vec_out        (vec_out),
    .busy           (busy),
    .done           (done),
    .pass           (pass),
    .err_cnt        (err_cnt),
    .first_fail     (first_fail),
    .first_fail_vld (first_fail_vld)
  );

  always #5 clk = ~clk;

  always_comb begin
    f_in = ^vec_out;
    case (dut_mode)
      M_XNOR:   f_in = ~(^vec_out);
      M_FAULT5: f_in = (^vec_out) ^ (vec_out == 3'd5);
      default:  f_in = ^vec_out;
    endcase
  end

  function automatic logic model_f(input int mode, input int v);
    logic p;
    p = ^(v[N_IN-1:0]);
    if (mode == M_XNOR) return ~p;
    if (mode == M_FAULT5 && v == 5) return ~p;
    return p;
  endfunction

  function automatic result_t model_sweep(input int mode);
    result_t r;
    r.err = 0; r.ff = 0; r.vld = 0;
    r.cycles = NVEC * (SETTLE + 1);
    for (int v = 0; v < NVEC; v++) begin
      if (model_f(mode, v) != logic'(^(v[N_IN-1:0]))) begin
        r.err++;
        if (r.vld == 0) begin
          r.ff = v;
          r.vld = 1;
        end
`ifdef TTC_STOP_ON_FAIL_EN
        r.cycles = (v + 1) * (SETTLE + 1);
        break;
`endif
      end
    end
    r.pass = (r.err == 0) ? 1 : 0;
    return r;
  endfunction

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Starts a sweep at a negedge and follows it to done; inject_at pulses start mid-sweep.
  task automatic run_sweep(input int mode, input bit check_steps, input int inject_at);
    result_t exp_r;
    int n;
    dut_mode = mode;
    sb_q.push_back(model_sweep(mode));
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("done_clr", int'(done), 0);
    chk("err_clr", int'(err_cnt), 0);
    chk("busy_on", int'(busy), 1);
    n = 0;
    while (!done && n < 500) begin
      if (check_steps) chk("vec_step", int'(vec_out), n / (SETTLE + 1));
      start = (n == inject_at);
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    if (sb_q.size() == 0) begin
      chk("sb_empty", 1, 0);
    end else begin
      exp_r = sb_q.pop_front();
      chk("latency", n, exp_r.cycles);
      chk("err_cnt", int'(err_cnt), exp_r.err);
      chk("first_fail", int'(first_fail), exp_r.ff);
      chk("first_fail_vld", int'(first_fail_vld), exp_r.vld);
      chk("pass", int'(pass), exp_r.pass);
      chk("busy_off", int'(busy), 0);
      chk("vec_hold", int'(vec_out), exp_r.ff * exp_r.vld + (exp_r.cycles / (SETTLE + 1) - 1) * (1 - exp_r.vld)
          + ((exp_r.vld == 1 && exp_r.cycles == NVEC * (SETTLE + 1)) ? (NVEC - 1 - exp_r.ff) : 0));
    end
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_vec"}, int'(vec_out), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_pass"}, int'(pass), 0);
    chk({tag, "_err"}, int'(err_cnt), 0);
    chk({tag, "_ff"}, int'(first_fail), 0);
    chk({tag, "_vld"}, int'(first_fail_vld), 0);
  endtask

  initial begin
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_vals("rst");
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_no_start", int'(busy), 0);

    run_sweep(M_XOR, 1'b1, -1);
    run_sweep(M_XNOR, 1'b0, -1);
    run_sweep(M_FAULT5, 1'b0, -1);

    // start while busy must not restart or shorten the sweep
    run_sweep(M_FAULT5, 1'b0, 10);
    run_sweep(M_FAULT5, 1'b0, -1);

    dut_mode = M_XNOR;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    #2 reset_n = 1'b0;
    #1 check_reset_vals("midrst");
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("post_rst_idle", int'(busy), 0);
    run_sweep(M_XOR, 1'b1, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
